fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Output reorder stage placed directly downstream of the pipelined FFT core. It accepts the core's bit-reversed-order output stream (valid-only, no backpressure) and writes each frame of FFT_POINTS complex samples into one bank of a ping-pong buffer at bit-reversed addresses. It then drains the frame in natural bin order (X[0]..X[N-1]) over a valid/ready handshake. Two banks allow one frame to be written while the previous frame drains.

## Interface
- DATA_WIDTH, 16, width of each real/imag sample
- FFT_POINTS, 64, frame length; power of 2, ≥ 4
- ADDR_WIDTH, 6, log2(FFT_POINTS)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample strobe, driven by FFT core data_out_valid
- in_real  in  DATA_WIDTH  input real part, bit-reversed order
- in_imag  in  DATA_WIDTH  input imaginary part
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the output sample
- out_real  out  DATA_WIDTH  output real part, natural order
- out_imag  out  DATA_WIDTH  output imaginary part
- out_index  out  ADDR_WIDTH  bin number of the current output sample
- out_last  out  1  asserted with bin FFT_POINTS-1
- busy  out  1  any bank is filling-with-data, full, or draining
- overflow  out  1  sticky dropped-sample flag

## Operation
- Storage: 2 banks × FFT_POINTS × 2·DATA_WIDTH. Per-bank full flag `bank_full[b]`.
- Write side: `wbank` (1 bit) and `wcnt` (ADDR_WIDTH bits).
  - When in_valid=1 and bank_full[wbank]=0, write to mem[wbank][bitrev(wcnt)] and increment wcnt.
  - On wcnt = FFT_POINTS-1: set bank_full[wbank], toggle wbank, and wrap wcnt to 0.
- Drop rule: when in_valid=1 and bank_full[wbank]=1, the sample is discarded and wcnt is unchanged.
- Read FSM:
  - R_IDLE → R_DRAIN when bank_full[rbank]=1. The output register is loaded with mem[rbank][0], out_index=0 and out_valid=1.
  - R_DRAIN: on out_valid & out_ready with rcnt < FFT_POINTS-1, load mem[rbank][rcnt+1] and increment rcnt.
  - R_DRAIN, handshake on rcnt = FFT_POINTS-1 (out_last=1):
    - Clear bank_full[rbank], toggle rbank, and wrap rcnt to 0.
    - If the other bank is already full, load its bin 0 in the same cycle and stay in R_DRAIN, giving zero bubbles.
    - Otherwise go to R_IDLE with out_valid=0.
- Output register holds stable while out_valid=1 and out_ready=0.
- Simultaneous set and clear of different banks' full flags in one cycle are both honoured.
- A write into the bank released in the same cycle is dropped. The full flag is cleared at the edge, so acceptance resumes in the next cycle.
- busy = bank_full[0] | bank_full[1] | (wcnt≠0) | out_valid.

## Timing
- Reset values:
  - out_valid=0, out_real=0, out_imag=0, out_index=0, out_last=0, busy=0, overflow=0.
  - wbank=rbank=0, wcnt=rcnt=0, bank_full=00, FSM=R_IDLE.
- Reset mid-frame discards all partial and full frames. Memory contents are not cleared.
- Latency: last input sample accepted at edge E sets bank_full at E. out_valid=1 with bin 0 from edge E+1.
- Throughput: 1 sample/cycle with out_ready held high; consecutive frames drain back-to-back.
- Memory read is asynchronous (combinational) feeding the output register. Write-to-read of the same address never occurs, because the banks are disjoint.

## Configuration
- FFT_REORDER_OVF_EN defined:
  - overflow is set on any dropped sample and held until rst_n.
- FFT_REORDER_OVF_EN undefined:
  - overflow is tied to 0 and the detection logic is removed.
  - The drop behaviour is unchanged.

## Structure
- Shared package fft_pkg holds:
  - FFT_POINTS/ADDR_WIDTH defaults
  - the bit-reverse function bitrev(ADDR_WIDTH)
  - the read-FSM state encoding (R_IDLE=0, R_DRAIN=1)
- One sub-module, fft_pingpong_ram: the 2-bank dual-port storage, with 1 write port and 1 asynchronous read port, indexed by {bank, addr}.

## Test plan
- Single frame, FFT_POINTS=64, out_ready=1: input value k arrives at cycle k in order bitrev(k).
  - Output must be 0..63 in natural order, out_index equal to the value, out_last only on 63.
  - First out_valid must come 1 cycle after the last input.
- Backpressure: out_ready toggles 1,0,0,1 repeating. Every held sample must stay stable, with no loss or duplication across the 64 bins.
- Back-to-back 3 frames with out_ready=1:
  - Outputs must run continuously, frames in arrival order.
  - out_valid never drops between frames.
  - No overflow.
- Overflow: out_ready=0 while 3 full frames are presented.
  - Frame 3 samples are dropped and overflow=1 with the macro defined; overflow stays 0 with it undefined.
  - Frames 1 and 2 later drain intact.
- Reset mid-operation: assert rst_n=0 at sample 30 of frame 2 while frame 1 is draining.
  - All outputs must go to reset values immediately.
  - A fresh frame afterwards must emerge correctly from bank 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder stage: default sizes,
// the read-FSM state encoding and the address bit-reversal helper.
// No logic, no latency, no flow control.
package fft_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FFT_POINTS_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 6;

  // Widest address the bit-reversal helper handles; callers cast in/out.
  localparam int BITREV_MAX = 16;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_t;

  // Reverse the low 'width' bits of 'a'; bits at and above 'width' are zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] a,
                                                   input int width);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX; i++) begin
      if (i < width) begin
        r[i] = a[width-1-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one asynchronous read port.
// Latency: write visible after the clock edge; read is combinational.
// Backpressure: none, the write port accepts whenever we=1.
module fft_pingpong_ram #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH:0]   waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH:0]   raddr,
  output logic [WORD_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

  // Address MSB selects the bank, the rest is the bin within the bank.
  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order via a ping-pong buffer.
// Latency: bin 0 is presented one cycle after the last sample of a frame is written.
// Backpressure: input has none (samples dropped when the target bank is full); output is valid/ready.
// Optional: define FFT_REORDER_OVF_EN to enable the sticky overflow flag on dropped samples.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FFT_POINTS = FFT_POINTS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow
);

  localparam int                  SW       = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(FFT_POINTS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO     = '0;

  // Write side state
  logic                  wbank;
  logic [ADDR_WIDTH-1:0] wcnt;
  logic [1:0]            bank_full;

  // Read side state
  rd_state_t             rstate;
  logic                  rbank;
  logic [ADDR_WIDTH-1:0] rcnt;

  logic                  wr_en;
  logic                  wr_done;
  logic                  wr_drop;
  logic [ADDR_WIDTH-1:0] wr_rev;
  logic [ADDR_WIDTH:0]   wr_addr;
  logic                  rd_fire;
  logic                  rd_done;
  logic [ADDR_WIDTH-1:0] rcnt_nxt;
  logic [ADDR_WIDTH:0]   rd_addr;
  logic [SW-1:0]         rd_data;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;

  // A sample is taken only if its target bank is free; otherwise it is lost.
  assign wr_en   = in_valid & ~bank_full[wbank];
  assign wr_drop = in_valid &  bank_full[wbank];
  assign wr_done = wr_en & (wcnt == LAST_BIN);
  assign wr_rev  = ADDR_WIDTH'(bitrev(BITREV_MAX'(wcnt), ADDR_WIDTH));
  assign wr_addr = {wbank, wr_rev};

  assign rd_fire  = out_valid & out_ready;
  assign rd_done  = rd_fire & (rcnt == LAST_BIN);
  assign rcnt_nxt = rcnt + ONE;

  fft_pingpong_ram #(
    .WORD_WIDTH (SW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata ({in_real, in_imag}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Read address: next bin to load into the output register, or bin 0 of the
  // other bank when the current frame is on its last bin.
  always_comb begin
    rd_addr = {rbank, ZERO};
    if (rstate == R_DRAIN) begin
      if (rcnt != LAST_BIN) begin
        rd_addr = {rbank, rcnt_nxt};
      end else begin
        rd_addr = {~rbank, ZERO};
      end
    end
  end

  // Full-flag set/clear requests; they always target different banks.
  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (wr_done) begin
      full_set[wbank] = 1'b1;
    end
    if (rd_done) begin
      full_clr[rbank] = 1'b1;
    end
  end

  // Write pointer: bit-reversed fill of the current bank, flip banks on the last bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank <= 1'b0;
      wcnt  <= '0;
    end else if (wr_en) begin
      if (wr_done) begin
        wbank <= ~wbank;
        wcnt  <= '0;
      end else begin
        wcnt  <= wcnt + ONE;
      end
    end
  end

  // Bank ownership: writer sets on frame completion, reader clears on last handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full & ~full_clr) | full_set;
    end
  end

  // Read FSM with registered outputs; chains directly into the other bank when it is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate    <= R_IDLE;
      rbank     <= 1'b0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (bank_full[rbank]) begin
            rstate    <= R_DRAIN;
            rcnt      <= '0;
            out_valid <= 1'b1;
            out_real  <= rd_data[SW-1:DATA_WIDTH];
            out_imag  <= rd_data[DATA_WIDTH-1:0];
            out_index <= '0;
            out_last  <= (LAST_BIN == ZERO);
          end
        end
        R_DRAIN: begin
          if (rd_fire) begin
            if (!rd_done) begin
              rcnt      <= rcnt_nxt;
              out_real  <= rd_data[SW-1:DATA_WIDTH];
              out_imag  <= rd_data[DATA_WIDTH-1:0];
              out_index <= rcnt_nxt;
              out_last  <= (rcnt_nxt == LAST_BIN);
            end else begin
              rbank     <= ~rbank;
              rcnt      <= '0;
              out_index <= '0;
              out_last  <= 1'b0;
              if (bank_full[~rbank]) begin
                out_real <= rd_data[SW-1:DATA_WIDTH];
                out_imag <= rd_data[DATA_WIDTH-1:0];
              end else begin
                rstate    <= R_IDLE;
                out_valid <= 1'b0;
              end
            end
          end
        end
        default: begin
          rstate    <= R_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = bank_full[0] | bank_full[1] | (wcnt != ZERO) | out_valid;

`ifdef FFT_REORDER_OVF_EN
  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end
  end
`else
  // Drop detection is not built; the drop signal is folded away.
  logic unused_drop;
  assign unused_drop = wr_drop;
  assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: single frame, backpressure,
// back-to-back frames, overflow with stalled output, and reset mid-operation.
module tb_fft_bitrev_reorder;

  localparam int DW = 16;
  localparam int NP = 64;
  localparam int AW = 6;

`ifdef FFT_REORDER_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  fft_bitrev_reorder #(
    .DATA_WIDTH (DW),
    .FFT_POINTS (NP),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] rev6(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // Bin k of frame f carries real = f*256+k, imag = real ^ 0x5A5A.
  function automatic logic [DW-1:0] re_val(input int f, input int k);
    return DW'(f * 256 + k);
  endfunction

  function automatic logic [DW-1:0] im_val(input int f, input int k);
    return re_val(f, k) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents n samples of frame f in bit-reversed order, one per cycle.
  // Entered and left at a falling edge; in_valid stays as last driven.
  task automatic send_frame(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_real  = re_val(f, int'(rev6(AW'(i))));
      in_imag  = im_val(f, int'(rev6(AW'(i))));
      @(negedge clk);
    end
  endtask

  // Consumes one frame with the given ready pattern (bit c%4 per cycle).
  // strict: an invalid cycle before the first bin is also an error.
  task automatic collect(input int f, input logic [3:0] pat, input bit strict, input int budget);
    int   b;
    int   cyc;
    logic r;
    b   = 0;
    cyc = 0;
    while (b < NP && cyc < budget) begin
      r         = pat[cyc % 4];
      out_ready = r;
      if (out_valid) begin
        chk($sformatf("f%0d_b%0d_real", f, b), 32'(out_real), 32'(re_val(f, b)));
        chk($sformatf("f%0d_b%0d_imag", f, b), 32'(out_imag), 32'(im_val(f, b)));
        chk($sformatf("f%0d_b%0d_index", f, b), 32'(out_index), 32'(b));
        chk($sformatf("f%0d_b%0d_last", f, b), 32'(out_last), 32'(b == NP - 1));
        if (r) b++;
      end else if (strict || b > 0) begin
        chk($sformatf("f%0d_b%0d_bubble", f, b), 32'(out_valid), 32'd1);
      end
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("f%0d_count", f), 32'(b), 32'(NP));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_real",  32'(out_real),  32'd0);
    chk("rst_imag",  32'(out_imag),  32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, ready high; bin 0 valid the cycle after the last write
    out_ready = 1'b1;
    send_frame(0, NP);
    in_valid = 1'b0;
    chk("t1_valid_at_last", 32'(out_valid), 32'd0);
    chk("t1_busy_full",     32'(busy),      32'd1);
    @(negedge clk);
    chk("t1_valid_next",    32'(out_valid), 32'd1);
    collect(0, 4'b1111, 1'b1, 100);
    chk("t1_valid_after", 32'(out_valid), 32'd0);
    chk("t1_busy_after",  32'(busy),      32'd0);

    // Backpressure: ready 1,0,0,1 repeating
    send_frame(1, NP);
    in_valid = 1'b0;
    collect(1, 4'b1001, 1'b0, 400);
    chk("t2_valid_after", 32'(out_valid), 32'd0);

    // Back-to-back frames. Frames 2 and 3 are contiguous, so frame 3 is full
    // before frame 2 finishes draining and the hand-over must be gapless.
    // Frame 4 starts one idle cycle later: its first sample would otherwise
    // land in bank 0 on the very edge that bank is released and be dropped.
    out_ready = 1'b1;
    fork
      begin
        send_frame(2, NP);
        send_frame(3, NP);
        in_valid = 1'b0;
        @(negedge clk);
        send_frame(4, NP);
        in_valid = 1'b0;
      end
      begin
        collect(2, 4'b1111, 1'b0, 200);
        collect(3, 4'b1111, 1'b1, 100);
        collect(4, 4'b1111, 1'b0, 100);
      end
    join
    chk("t3_ovf",         32'(overflow),  32'd0);
    chk("t3_valid_after", 32'(out_valid), 32'd0);

    // Overflow: output stalled, third frame has nowhere to go
    out_ready = 1'b0;
    send_frame(5, NP);
    send_frame(6, NP);
    send_frame(7, NP);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_ovf",        32'(overflow),  32'(OVF_EXP));
    chk("t4_valid_held", 32'(out_valid), 32'd1);
    chk("t4_busy",       32'(busy),      32'd1);
    collect(5, 4'b1111, 1'b1, 100);
    collect(6, 4'b1111, 1'b1, 100);
    chk("t4_valid_after", 32'(out_valid), 32'd0);
    chk("t4_busy_after",  32'(busy),      32'd0);
    chk("t4_ovf_sticky",  32'(overflow),  32'(OVF_EXP));

    // Reset at sample 30 of the next frame while the previous one drains
    out_ready = 1'b1;
    send_frame(8, NP);
    send_frame(9, 30);
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_real",  32'(out_real),  32'd0);
    chk("t5_rst_imag",  32'(out_imag),  32'd0);
    chk("t5_rst_index", 32'(out_index), 32'd0);
    chk("t5_rst_last",  32'(out_last),  32'd0);
    chk("t5_rst_busy",  32'(busy),      32'd0);
    chk("t5_rst_ovf",   32'(overflow),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(10, NP);
    in_valid = 1'b0;
    chk("t5_valid_at_last", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t5_valid_next", 32'(out_valid), 32'd1);
    collect(10, 4'b1111, 1'b1, 100);
    chk("t5_valid_after", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
